// File: rtl/cgra_launch_ctrl_if.sv
// ---------------------------------------------------------------------------
// cgra_launch_ctrl_if
// Peripheral register bus between the core's bus decoder and the CGRA launch
// controller. Each strobe is a single-cycle request. Read data returns one
// cycle after reg_re, qualified by reg_rvalid.
//
// Signals:
//   reg_we     register write strobe, one cycle per write
//   reg_re     register read strobe, one cycle per read
//   reg_addr   byte offset; [3:2] select the register, [1:0] ignored
//   reg_wdata  write data
//   reg_rdata  read data, valid while reg_rvalid=1, held otherwise
//   reg_rvalid one-cycle pulse one cycle after reg_re
//
// Modports:
//   master  bus decoder side (drives strobes, address and write data)
//   slave   launch controller side (drives read data and read valid)
// ---------------------------------------------------------------------------
interface cgra_launch_ctrl_if;
   logic        reg_we;
   logic        reg_re;
   logic [3:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        reg_rvalid;

   modport master (
      output reg_we,
      output reg_re,
      output reg_addr,
      output reg_wdata,
      input  reg_rdata,
      input  reg_rvalid
   );

   modport slave (
      input  reg_we,
      input  reg_re,
      input  reg_addr,
      input  reg_wdata,
      output reg_rdata,
      output reg_rvalid
   );
endinterface

// File: rtl/cgra_launch_ctrl.sv
// ---------------------------------------------------------------------------
// cgra_launch_ctrl
// Launch controller that sequences one CGRA array run on behalf of the core.
// The core programs CTRL/TIMEOUT, the block holds cgra_start high for the
// run, detects completion on the rising edge of cgra_done, captures the
// error code, enforces an optional cycle timeout, supports abort, and raises
// a level interrupt.
//
// Register map (byte offsets):
//   0x0 CTRL    W: [0] START cmd, [1] ABORT cmd, [2] IRQ_EN   R: {IRQ_EN,2'b0}
//   0x4 STATUS  R: [0] BUSY [1] DONE [2] TO [3] ABORTED [5:4] ERR
//               W: write-1-to-clear on [3:1]
//   0x8 TIMEOUT RW, low CNT_W bits; 0 disables the timeout
//   0xC CYCLES  RO, length in cycles of the current or last run
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         register bus (slave side)
//   cgra_start  CGRA Start level, high for the whole run
//   cgra_done   CGRA Done input
//   cgra_error  CGRA Error code, captured on the Done rising edge
//   irq         level interrupt, IRQ_EN & (DONE|TO|ABORTED), registered
// ---------------------------------------------------------------------------
module cgra_launch_ctrl #(
   parameter int unsigned TIMEOUT_DEFAULT = 1024,
   parameter int unsigned CNT_W           = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   cgra_launch_ctrl_if.slave     bus,
   output logic                  cgra_start,
   input  logic                  cgra_done,
   input  logic [1:0]            cgra_error,
   output logic                  irq
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   localparam logic [1:0] A_CTRL    = 2'd0;
   localparam logic [1:0] A_STATUS  = 2'd1;
   localparam logic [1:0] A_TIMEOUT = 2'd2;
   localparam logic [1:0] A_CYCLES  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             done_q, done_d;
   logic             sts_done_q, sts_done_d;
   logic             sts_to_q, sts_to_d;
   logic             sts_abort_q, sts_abort_d;
   logic [1:0]       err_q, err_d;
   logic             irq_en_q, irq_en_d;
   logic [CNT_W-1:0] timeout_q, timeout_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;
   logic             irq_q, irq_d;

   logic             wr_ctrl, wr_status, wr_timeout;
   logic             cmd_start, cmd_abort;
   logic             busy;
   logic             done_rise;
   logic [CNT_W:0]   cyc_inc;
   logic             to_hit;

   // Address bits [1:0] are ignored by design; not every write-data bit is
   // meaningful for every register.
   logic unused_bus_bits;
   assign unused_bus_bits = ^{bus.reg_addr[1:0], bus.reg_wdata};

   assign wr_ctrl    = bus.reg_we && (bus.reg_addr[3:2] == A_CTRL);
   assign wr_status  = bus.reg_we && (bus.reg_addr[3:2] == A_STATUS);
   assign wr_timeout = bus.reg_we && (bus.reg_addr[3:2] == A_TIMEOUT);
   assign cmd_start  = wr_ctrl && bus.reg_wdata[0];
   assign cmd_abort  = wr_ctrl && bus.reg_wdata[1];

   assign busy       = (state_q != ST_IDLE);

   // Only the rising edge counts as completion: a Done level still high from
   // the previous run must not finish the new one.
   assign done_rise  = cgra_done && !done_q;

   // One bit wider than the counter so a saturated counter never wraps into
   // a false timeout match.
   assign cyc_inc    = {1'b0, cycles_q} + {{CNT_W{1'b0}}, 1'b1};
   assign to_hit     = (timeout_q != '0) && (cyc_inc == {1'b0, timeout_q});

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      done_d      = cgra_done;
      sts_done_d  = sts_done_q;
      sts_to_d    = sts_to_q;
      sts_abort_d = sts_abort_q;
      err_d       = err_q;
      irq_en_d    = irq_en_q;
      timeout_d   = timeout_q;
      cycles_d    = cycles_q;
      rdata_d     = rdata_q;
      rvalid_d    = bus.reg_re;

      if (wr_ctrl)    irq_en_d  = bus.reg_wdata[2];
      if (wr_timeout) timeout_d = bus.reg_wdata[CNT_W-1:0];

      // W1C is applied before the FSM so a hardware set in the same cycle
      // overrides the clear.
      if (wr_status) begin
         if (bus.reg_wdata[1]) sts_done_d  = 1'b0;
         if (bus.reg_wdata[2]) sts_to_d    = 1'b0;
         if (bus.reg_wdata[3]) sts_abort_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            // START wins over a simultaneous ABORT; ABORT alone is ignored.
            if (cmd_start) begin
               state_d     = ST_RUN;
               sts_done_d  = 1'b0;
               sts_to_d    = 1'b0;
               sts_abort_d = 1'b0;
               err_d       = 2'b00;
               cycles_d    = '0;
            end
         end
         ST_RUN: begin
            // The exit cycle is counted, so the first RUN cycle yields 1.
            cycles_d = (&cycles_q) ? cycles_q : cyc_inc[CNT_W-1:0];
            if (done_rise) begin
               err_d      = cgra_error;
               sts_done_d = 1'b1;
               state_d    = ST_FINISH;
            end else if (cmd_abort) begin
               sts_abort_d = 1'b1;
               state_d     = ST_FINISH;
            end else if (to_hit) begin
               sts_to_d = 1'b1;
               state_d  = ST_FINISH;
            end
         end
         ST_FINISH: begin
            // One Start-low cycle is guaranteed between consecutive runs.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      irq_d = irq_en_q && (sts_done_q || sts_to_q || sts_abort_q);

      // Reads see the pre-write register state of the same cycle.
      if (bus.reg_re) begin
         case (bus.reg_addr[3:2])
            A_CTRL:    rdata_d = {29'b0, irq_en_q, 2'b00};
            A_STATUS:  rdata_d = {26'b0, err_q, sts_abort_q, sts_to_q,
                                  sts_done_q, busy};
            A_TIMEOUT: rdata_d = 32'(timeout_q);
            A_CYCLES:  rdata_d = 32'(cycles_q);
            default:   rdata_d = 32'b0;
         endcase
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         done_q      <= 1'b0;
         sts_done_q  <= 1'b0;
         sts_to_q    <= 1'b0;
         sts_abort_q <= 1'b0;
         err_q       <= 2'b00;
         irq_en_q    <= 1'b0;
         timeout_q   <= CNT_W'(TIMEOUT_DEFAULT);
         cycles_q    <= '0;
         rdata_q     <= 32'b0;
         rvalid_q    <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         sts_done_q  <= sts_done_d;
         sts_to_q    <= sts_to_d;
         sts_abort_q <= sts_abort_d;
         err_q       <= err_d;
         irq_en_q    <= irq_en_d;
         timeout_q   <= timeout_d;
         cycles_q    <= cycles_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         irq_q       <= irq_d;
      end
   end

   assign cgra_start     = (state_q == ST_RUN);
   assign irq            = irq_q;
   assign bus.reg_rdata  = rdata_q;
   assign bus.reg_rvalid = rvalid_q;

endmodule

// File: tb/tb_cgra_launch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cgra_launch_ctrl
// Directed bench for cgra_launch_ctrl. Inputs change 1 time unit after the
// rising edge, outputs are sampled at the same point, so every input is
// captured on the following edge. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_cgra_launch_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cgra_start;
   logic       cgra_done;
   logic [1:0] cgra_error;
   logic       irq;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   cgra_launch_ctrl_if bus ();

   cgra_launch_ctrl #(
      .TIMEOUT_DEFAULT (1024),
      .CNT_W           (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .cgra_start (cgra_start),
      .cgra_done  (cgra_done),
      .cgra_error (cgra_error),
      .irq        (irq)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
      bus.reg_we    = 1'b1;
      bus.reg_addr  = a;
      bus.reg_wdata = d;
      tick();
      bus.reg_we    = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [3:0] a,
                             input logic [31:0] exp);
      bus.reg_re   = 1'b1;
      bus.reg_addr = a;
      tick();
      bus.reg_re   = 1'b0;
      check({tag, "_rvalid"}, 32'(bus.reg_rvalid), 32'd1);
      check(tag, bus.reg_rdata, exp);
   endtask

   // Walks a run cycle by cycle while cgra_start is high. n counts Start-high
   // cycles; at chosen counts it drops/raises Done or issues a CTRL write.
   task automatic run_watch(input int max_cyc, input int lo_at, input int hi_at,
                            input logic [1:0] err,
                            input int w1_at, input logic [31:0] w1_d,
                            input int w2_at, input logic [31:0] w2_d,
                            output int n);
      n = 0;
      for (int i = 0; i < max_cyc; i++) begin
         bus.reg_we = 1'b0;
         if (!cgra_start) break;
         n++;
         if (n == lo_at) cgra_done = 1'b0;
         if (n == hi_at) begin
            cgra_done  = 1'b1;
            cgra_error = err;
         end
         if (n == w1_at) begin
            bus.reg_we    = 1'b1;
            bus.reg_addr  = 4'h0;
            bus.reg_wdata = w1_d;
         end
         if (n == w2_at) begin
            bus.reg_we    = 1'b1;
            bus.reg_addr  = 4'h0;
            bus.reg_wdata = w2_d;
         end
         tick();
      end
      bus.reg_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      rst           = 1'b1;
      cgra_done     = 1'b0;
      cgra_error    = 2'b00;
      bus.reg_we    = 1'b0;
      bus.reg_re    = 1'b0;
      bus.reg_addr  = 4'h0;
      bus.reg_wdata = 32'h0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_start",  32'(cgra_start), 32'd0);
      check("rst_irq",    32'(irq), 32'd0);
      check("rst_rvalid", 32'(bus.reg_rvalid), 32'd0);
      check("rst_rdata",  bus.reg_rdata, 32'd0);
      read_check("rst_timeout", 4'h8, 32'd1024);
      read_check("rst_status",  4'h4, 32'h0);
      read_check("rst_cycles",  4'hC, 32'd0);

      // Normal run: Done with Error=3 on the 12th Start cycle
      reg_write(4'h8, 32'd100);
      reg_write(4'h0, 32'h5);
      run_watch(40, 0, 12, 2'b11, 0, 32'h0, 0, 32'h0, n);
      check("t1_start_cycles", 32'(n), 32'd12);
      check("t1_finish_start", 32'(cgra_start), 32'd0);
      check("t1_irq_lag", 32'(irq), 32'd0);
      cgra_done  = 1'b0;
      cgra_error = 2'b00;
      read_check("t1_status_finish", 4'h4, 32'h33);
      check("t1_irq", 32'(irq), 32'd1);
      read_check("t1_status", 4'h4, 32'h32);
      read_check("t1_cycles", 4'hC, 32'd12);
      read_check("t1_ctrl",   4'h0, 32'h4);
      reg_write(4'h4, 32'h2);
      check("t1_irq_hold", 32'(irq), 32'd1);
      tick();
      check("t1_irq_clr", 32'(irq), 32'd0);
      read_check("t1_status_w1c", 4'h4, 32'h30);

      // Simultaneous write and read returns the pre-write value
      bus.reg_we    = 1'b1;
      bus.reg_re    = 1'b1;
      bus.reg_addr  = 4'h8;
      bus.reg_wdata = 32'd5;
      tick();
      bus.reg_we = 1'b0;
      bus.reg_re = 1'b0;
      check("wr_rd_rvalid", 32'(bus.reg_rvalid), 32'd1);
      check("wr_rd_old", bus.reg_rdata, 32'd100);
      read_check("wr_rd_new", 4'h8, 32'd5);

      // Timeout after 5 cycles, Done never rises, IRQ disabled
      reg_write(4'h0, 32'h1);
      run_watch(40, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0, n);
      check("t2_start_cycles", 32'(n), 32'd5);
      tick();
      read_check("t2_status", 4'h4, 32'h4);
      read_check("t2_cycles", 4'hC, 32'd5);
      check("t2_irq", 32'(irq), 32'd0);

      // Done rise and timeout in the same cycle: Done wins
      reg_write(4'h8, 32'd12);
      reg_write(4'h0, 32'h1);
      run_watch(40, 0, 12, 2'b11, 0, 32'h0, 0, 32'h0, n);
      check("t3_start_cycles", 32'(n), 32'd12);
      cgra_done  = 1'b0;
      cgra_error = 2'b00;
      tick();
      read_check("t3_status", 4'h4, 32'h32);
      read_check("t3_cycles", 4'hC, 32'd12);

      // Stale Done held high before launch
      reg_write(4'h8, 32'd100);
      cgra_done = 1'b1;
      tick();
      tick();
      reg_write(4'h0, 32'h1);
      run_watch(40, 2, 11, 2'b00, 0, 32'h0, 0, 32'h0, n);
      check("t4_start_cycles", 32'(n), 32'd11);
      cgra_done = 1'b0;
      tick();
      read_check("t4_status", 4'h4, 32'h2);
      read_check("t4_cycles", 4'hC, 32'd11);

      // START during RUN is ignored, ABORT at cycle 3
      reg_write(4'h0, 32'h1);
      run_watch(40, 0, 0, 2'b00, 1, 32'h1, 3, 32'h2, n);
      check("t5_start_cycles", 32'(n), 32'd3);
      for (int i = 0; i < 5; i++) tick();
      check("t5_single_run", 32'(cgra_start), 32'd0);
      read_check("t5_status", 4'h4, 32'h8);
      read_check("t5_cycles", 4'hC, 32'd3);
      reg_write(4'h4, 32'h8);
      reg_write(4'h0, 32'h2);
      read_check("t5_idle_abort", 4'h4, 32'h0);
      check("t5_idle_start", 32'(cgra_start), 32'd0);

      // Reset in the 4th RUN cycle
      reg_write(4'h8, 32'd50);
      reg_write(4'h0, 32'h5);
      tick();
      tick();
      tick();
      check("t6_running", 32'(cgra_start), 32'd1);
      rst          = 1'b1;
      bus.reg_re   = 1'b1;
      bus.reg_addr = 4'h8;
      tick();
      rst        = 1'b0;
      bus.reg_re = 1'b0;
      check("t6_start",  32'(cgra_start), 32'd0);
      check("t6_rvalid", 32'(bus.reg_rvalid), 32'd0);
      check("t6_rdata",  bus.reg_rdata, 32'd0);
      check("t6_irq",    32'(irq), 32'd0);
      read_check("t6_status",  4'h4, 32'h0);
      read_check("t6_timeout", 4'h8, 32'd1024);
      read_check("t6_cycles",  4'hC, 32'd0);
      read_check("t6_ctrl",    4'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
